// File: rtl/time_keeper_if.sv
// Signal bundle between the push-button/display side and time_keeper.
// Alarm signals exist only when TIME_KEEPER_ALARM_EN is defined.
interface time_keeper_if;
    logic       run;
    logic       incMinutes;
    logic       incHours;
    logic       mode12h;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       pm;
    logic       secondTick;
`ifdef TIME_KEEPER_ALARM_EN
    logic       alarmEnable;
    logic [4:0] alarmHours;
    logic [5:0] alarmMinutes;
    logic       alarmClear;
    logic       alarm;

    modport master (
        output run, incMinutes, incHours, mode12h,
        output alarmEnable, alarmHours, alarmMinutes, alarmClear,
        input  seconds, minutes, hours, pm, secondTick, alarm
    );
    modport slave (
        input  run, incMinutes, incHours, mode12h,
        input  alarmEnable, alarmHours, alarmMinutes, alarmClear,
        output seconds, minutes, hours, pm, secondTick, alarm
    );
`else
    modport master (
        output run, incMinutes, incHours, mode12h,
        input  seconds, minutes, hours, pm, secondTick
    );
    modport slave (
        input  run, incMinutes, incHours, mode12h,
        output seconds, minutes, hours, pm, secondTick
    );
`endif
endinterface

// File: rtl/time_keeper.sv
// Time-of-day counter (hh:mm:ss) with auto-repeat set inputs, run/stop and 12/24h display.
// Define TIME_KEEPER_ALARM_EN to add the hour:minute alarm.
module time_keeper #(
    parameter int ClockFrequency = 24_000_000,
    parameter int RepeatDelay    = 12_000_000,
    parameter int RepeatPeriod   = 4_800_000
) (
    input  logic         clock,
    input  logic         reset,
    time_keeper_if.slave bus
);
    localparam int PrescW = $clog2(ClockFrequency);
    localparam int RptW   = $clog2(RepeatDelay + 1);

    localparam logic [PrescW-1:0] PrescLast = PrescW'(ClockFrequency - 1);
    localparam logic [PrescW-1:0] PrescOne  = PrescW'(1);
    localparam logic [RptW-1:0]   RptOne    = RptW'(1);
    localparam logic [RptW-1:0]   RptFire   = RptW'(RepeatDelay);
    localparam logic [RptW-1:0]   RptReload = RptW'(RepeatDelay - RepeatPeriod + 1);

    logic [PrescW-1:0] presc_q, presc_d;
    logic [5:0]        sec_q, sec_d;
    logic [5:0]        min_q, min_d;
    logic [4:0]        hour_q, hour_d;
    logic              tick_q, tick_d;

    // Index 0 = incMinutes, index 1 = incHours.
    logic [1:0]        set_in;
    logic [1:0]        set_prev_q, set_prev_d;
    logic [1:0]        set_inc;
    logic [RptW-1:0]   rpt_cnt_q [2];
    logic [RptW-1:0]   rpt_cnt_d [2];

    logic              inc_min, inc_hr;
    logic              nat_tick, sec_wrap, min_wrap;
    logic [4:0]        hours_disp;

    assign set_in = {bus.incHours, bus.incMinutes};

    // rpt_cnt == 0 means idle; a rise loads 1 and the count tracks cycles since the edge.
    always_comb begin
        set_prev_d = set_in;
        for (int i = 0; i < 2; i++) begin
            // NOTE: every combinational output gets a default first so no path can infer a latch.
            set_inc[i]   = 1'b0;
            rpt_cnt_d[i] = '0;
            if (set_in[i]) begin
                if (!set_prev_q[i]) begin
                    set_inc[i]   = 1'b1;
                    rpt_cnt_d[i] = RptOne;
                end else if (rpt_cnt_q[i] == RptFire) begin
                    set_inc[i]   = 1'b1;
                    rpt_cnt_d[i] = RptReload;
                end else if (rpt_cnt_q[i] != '0) begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + RptOne;
                end
            end
        end
    end

    always_comb begin
        inc_min  = set_inc[0];
        inc_hr   = set_inc[1];
        // A minutes set restarts the second, so it swallows a coincident natural tick.
        nat_tick = bus.run && (presc_q == PrescLast) && !inc_min;
        sec_wrap = nat_tick && (sec_q == 6'd59);
        min_wrap = sec_wrap && (min_q == 6'd59);

        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        tick_d  = nat_tick;

        if (inc_min) begin
            presc_d = '0;
            sec_d   = 6'd0;
            min_d   = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end else if (nat_tick) begin
            presc_d = '0;
            sec_d   = sec_wrap ? 6'd0 : sec_q + 6'd1;
            if (sec_wrap) begin
                min_d = min_wrap ? 6'd0 : min_q + 6'd1;
            end
        end else if (bus.run) begin
            presc_d = presc_q + PrescOne;
        end

        // A set and a natural carry in the same cycle still advance the hour only once.
        if (inc_hr || min_wrap) begin
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
    end

    always_comb begin
        hours_disp = hour_q;
        if (bus.mode12h) begin
            if (hour_q == 5'd0) begin
                hours_disp = 5'd12;
            end else if (hour_q > 5'd12) begin
                hours_disp = hour_q - 5'd12;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hour_q     <= 5'd0;
            tick_q     <= 1'b0;
            // Treat the inputs as already high so a level held through reset is not an edge.
            set_prev_q <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            tick_q     <= tick_d;
            set_prev_q <= set_prev_d;
            for (int i = 0; i < 2; i++) begin
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end

    assign bus.seconds    = sec_q;
    assign bus.minutes    = min_q;
    assign bus.hours      = hours_disp;
    assign bus.pm         = (hour_q >= 5'd12);
    assign bus.secondTick = tick_q;

`ifdef TIME_KEEPER_ALARM_EN
    logic       alarm_q, alarm_d;
    logic [5:0] alarm_cnt_q, alarm_cnt_d;

    // Alarm arms only on a natural roll into a new minute; it lasts 60 natural seconds.
    always_comb begin
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        if (bus.alarmClear || !bus.alarmEnable) begin
            alarm_d     = 1'b0;
            alarm_cnt_d = 6'd0;
        end else if (alarm_q) begin
            if (nat_tick) begin
                if (alarm_cnt_q == 6'd59) begin
                    alarm_d     = 1'b0;
                    alarm_cnt_d = 6'd0;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + 6'd1;
                end
            end
        end else if (sec_wrap && !inc_hr &&
                     (min_d == bus.alarmMinutes) && (hour_d == bus.alarmHours)) begin
            alarm_d     = 1'b1;
            alarm_cnt_d = 6'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= 6'd0;
        end else begin
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign bus.alarm = alarm_q;
`endif
endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with a small clock (10 cycles/s) and short repeat timings.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_time_keeper;
    logic clock;
    logic reset;
    int   errors;
    int   checks;

    time_keeper_if bus ();

    time_keeper #(
        .ClockFrequency(10),
        .RepeatDelay   (20),
        .RepeatPeriod  (5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_min(input int n);
        repeat (n) begin
            bus.incMinutes = 1'b1;
            step(1);
            bus.incMinutes = 1'b0;
            step(1);
        end
    endtask

    task automatic pulse_hr(input int n);
        repeat (n) begin
            bus.incHours = 1'b1;
            step(1);
            bus.incHours = 1'b0;
            step(1);
        end
    endtask

    logic [5:0] min_trace [0:40];
    int         tick_cnt;
    int         first_tick;
    int         last_tick;
    int         bad_gap;
    int         next_tick;

    initial begin
        errors = 0;
        checks = 0;
        reset          = 1'b0;
        bus.run        = 1'b0;
        bus.incMinutes = 1'b0;
        bus.incHours   = 1'b0;
        bus.mode12h    = 1'b0;
`ifdef TIME_KEEPER_ALARM_EN
        bus.alarmEnable  = 1'b0;
        bus.alarmHours   = 5'd0;
        bus.alarmMinutes = 6'd0;
        bus.alarmClear   = 1'b0;
`endif
        step(2);

        // Reset values in both display modes
        check("rst_seconds", bus.seconds, 0);
        check("rst_minutes", bus.minutes, 0);
        check("rst_hours24", bus.hours, 0);
        check("rst_pm", bus.pm, 0);
        check("rst_tick", bus.secondTick, 0);
        bus.mode12h = 1'b1;
        #1;
        check("rst_hours12", bus.hours, 12);
        bus.mode12h = 1'b0;
        step(1);

        // 100 cycles of free running: ten evenly spaced ticks
        reset   = 1'b1;
        bus.run = 1'b1;
        tick_cnt = 0; first_tick = 0; last_tick = 0; bad_gap = 0;
        for (int k = 1; k <= 100; k++) begin
            step(1);
            if (bus.secondTick) begin
                tick_cnt++;
                if (first_tick == 0) first_tick = k;
                if (last_tick != 0 && (k - last_tick) != 10) bad_gap++;
                last_tick = k;
            end
        end
        check("run_tick_count", tick_cnt, 10);
        check("run_first_tick", first_tick, 10);
        check("run_bad_gaps", bad_gap, 0);
        check("run_seconds", bus.seconds, 10);

        // Preload 23:59:59, then roll over to midnight
        bus.run = 1'b0;
        pulse_hr(23);
        pulse_min(59);
        check("pre_seconds_cleared", bus.seconds, 0);
        bus.run = 1'b1;
        step(590);
        check("pre_seconds", bus.seconds, 59);
        check("pre_minutes", bus.minutes, 59);
        check("pre_hours24", bus.hours, 23);
        check("pre_pm", bus.pm, 1);
        bus.mode12h = 1'b1;
        #1;
        check("pre_hours12", bus.hours, 11);
        bus.mode12h = 1'b0;
        step(10);
        check("mid_tick", bus.secondTick, 1);
        check("mid_seconds", bus.seconds, 0);
        check("mid_minutes", bus.minutes, 0);
        check("mid_hours24", bus.hours, 0);
        check("mid_pm", bus.pm, 0);
        bus.mode12h = 1'b1;
        #1;
        check("mid_hours12", bus.hours, 12);
        check("mid_pm12", bus.pm, 0);
        bus.mode12h = 1'b0;
        bus.run     = 1'b0;

        // Auto-repeat from minutes=58: edge, delay of 20, then every 5
        pulse_min(58);
        check("rpt_start_minutes", bus.minutes, 58);
        bus.incMinutes = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            step(1);
            min_trace[k] = bus.minutes;
        end
        bus.incMinutes = 1'b0;
        check("rpt_k0", min_trace[0], 59);
        check("rpt_k19", min_trace[19], 59);
        check("rpt_k20", min_trace[20], 0);
        check("rpt_k24", min_trace[24], 0);
        check("rpt_k25", min_trace[25], 1);
        check("rpt_k29", min_trace[29], 1);
        check("rpt_k30", min_trace[30], 2);
        check("rpt_k35", min_trace[35], 3);
        check("rpt_k40", min_trace[40], 4);
        step(25);
        check("rpt_after_release", bus.minutes, 4);
        check("rpt_hours", bus.hours, 0);
        check("rpt_seconds", bus.seconds, 0);

        // Hour set wraps 23->0 without touching minutes
        pulse_hr(23);
        check("hset_23", bus.hours, 23);
        pulse_hr(1);
        check("hset_wrap_hours", bus.hours, 0);
        check("hset_wrap_minutes", bus.minutes, 4);

        // Minute set landing on a prescaler wrap at 10:20:30
        pulse_hr(10);
        pulse_min(16);
        bus.run = 1'b1;
        step(300);
        check("coin_pre_seconds", bus.seconds, 30);
        check("coin_pre_minutes", bus.minutes, 20);
        step(9);
        bus.incMinutes = 1'b1;
        step(1);
        bus.incMinutes = 1'b0;
        check("coin_tick_suppressed", bus.secondTick, 0);
        check("coin_minutes", bus.minutes, 21);
        check("coin_seconds", bus.seconds, 0);
        check("coin_hours", bus.hours, 10);
        next_tick = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (bus.secondTick && next_tick == 0) next_tick = i;
        end
        check("coin_next_tick_gap", next_tick, 10);

        // Hour 13: mode change is immediate, pm stays high
        bus.run = 1'b0;
        pulse_hr(3);
        check("h13_hours24", bus.hours, 13);
        check("h13_pm24", bus.pm, 1);
        bus.mode12h = 1'b1;
        #1;
        check("h13_hours12", bus.hours, 1);
        check("h13_pm12", bus.pm, 1);

        // Asynchronous reset mid-cycle with incHours held through release
        bus.incHours = 1'b1;
        step(1);
        check("ar_pre_hours12", bus.hours, 2);
        #2;
        reset = 1'b0;
        #1;
        check("ar_seconds", bus.seconds, 0);
        check("ar_minutes", bus.minutes, 0);
        check("ar_hours12", bus.hours, 12);
        check("ar_pm", bus.pm, 0);
        step(1);
        reset = 1'b1;
        step(3);
        check("ar_level_no_inc", bus.hours, 12);
        bus.incHours = 1'b0;
        step(1);
        check("ar_fall_no_inc", bus.hours, 12);
        bus.incHours = 1'b1;
        step(1);
        bus.incHours = 1'b0;
        check("ar_new_edge", bus.hours, 1);
        bus.mode12h = 1'b0;

        // Hour set coinciding with a natural minute->hour carry at 01:59:59
        pulse_min(59);
        bus.run = 1'b1;
        step(590);
        check("hc_pre_seconds", bus.seconds, 59);
        step(9);
        bus.incHours = 1'b1;
        step(1);
        bus.incHours = 1'b0;
        bus.run      = 1'b0;
        check("hc_hours", bus.hours, 2);
        check("hc_minutes", bus.minutes, 0);
        check("hc_seconds", bus.seconds, 0);
        check("hc_tick", bus.secondTick, 1);

`ifdef TIME_KEEPER_ALARM_EN
        // Alarm at 07:30: set on the roll, cleared by alarmClear, then by timeout
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        bus.alarmEnable  = 1'b1;
        bus.alarmHours   = 5'd7;
        bus.alarmMinutes = 6'd30;
        pulse_hr(7);
        pulse_min(29);
        bus.run = 1'b1;
        step(590);
        check("al_before", bus.alarm, 0);
        step(10);
        check("al_set_minutes", bus.minutes, 30);
        check("al_set", bus.alarm, 1);
        bus.alarmClear = 1'b1;
        step(1);
        bus.alarmClear = 1'b0;
        check("al_cleared", bus.alarm, 0);
        bus.run = 1'b0;
        pulse_min(59);
        check("al_rewind_minutes", bus.minutes, 29);
        bus.run = 1'b1;
        step(600);
        check("al_set_again", bus.alarm, 1);
        step(590);
        check("al_hold_59", bus.alarm, 1);
        step(10);
        check("al_timeout", bus.alarm, 0);
        bus.run = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
